// File: rtl/checkpoint_restore_pkg.sv
// Shared checkpoint configuration and types for the checkpoint producer/consumer blocks.
// Also holds the restore FSM state encoding.
package checkpoint_restore_pkg;

  localparam int CP_ID_W      = 3;
  localparam int GHR_W        = 16;
  localparam int LOCAL_HIST_W = 8;
  localparam int PHY_REG_NUM  = 32;

  typedef struct packed {
    logic [PHY_REG_NUM-1:0]  phy_map_table_valid;
    logic [PHY_REG_NUM-1:0]  phy_map_table_visible;
    logic [GHR_W-1:0]        global_history;
    logic [LOCAL_HIST_W-1:0] local_history;
  } checkpoint_t;

  typedef enum logic [1:0] {
    CPRST_IDLE    = 2'd0,
    CPRST_READ    = 2'd1,
    CPRST_RESTORE = 2'd2,
    CPRST_DONE    = 2'd3
  } cprst_state_t;

endpackage

// File: rtl/checkpoint_restore.sv
// Mispredict recovery: reads the tagged checkpoint and replays RAT maps to rename and
// corrected branch history to the predictor over two independent valid/ready channels.
module checkpoint_restore
  import checkpoint_restore_pkg::*;
#(
  parameter int CP_ID_WIDTH = CP_ID_W,
  parameter int GHR_WIDTH   = GHR_W,
  parameter bit UPDATE_GHR  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bru_cprst_req,
  input  logic [CP_ID_WIDTH-1:0]  bru_cprst_id,
  input  logic                    bru_cprst_taken,
  output logic                    cprst_bru_ready,
  output logic [CP_ID_WIDTH-1:0]  cprst_cpbuf_id,
  input  checkpoint_t             cpbuf_cprst_data,
  output logic                    cprst_rat_valid,
  output logic [PHY_REG_NUM-1:0]  cprst_rat_phy_map_table_valid,
  output logic [PHY_REG_NUM-1:0]  cprst_rat_phy_map_table_visible,
  input  logic                    rat_cprst_ready,
  output logic                    cprst_bp_valid,
  output logic [GHR_WIDTH-1:0]    cprst_bp_global_history,
  output logic [LOCAL_HIST_W-1:0] cprst_bp_local_history,
  input  logic                    bp_cprst_ready,
  input  logic                    commit_cprst_flush,
  output logic                    cprst_busy,
  output logic                    cprst_done,
  output cprst_state_t            cprst_state
);

  // Handshake rule for both restore channels: a transfer happens on a rising clk edge
  // where valid && ready; valid is a function of FSM state and done flags only (never of
  // ready), and the payload comes from registers that do not change while valid is high.

  cprst_state_t               state, state_nxt;
  logic [CP_ID_WIDTH-1:0]     id_q;
  logic                       taken_q;
  checkpoint_t                cap_q;
  logic                       rat_done, bp_done;
  logic                       rat_hs, bp_hs;

  assign rat_hs = cprst_rat_valid && rat_cprst_ready;
  assign bp_hs  = cprst_bp_valid && bp_cprst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CPRST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cprst_bru_ready = 1'b0;
    cprst_rat_valid = 1'b0;
    cprst_bp_valid  = 1'b0;
    cprst_done      = 1'b0;
    case (state)
      CPRST_IDLE: begin
        cprst_bru_ready = 1'b1;
        if (bru_cprst_req) state_nxt = CPRST_READ;
      end
      CPRST_READ: state_nxt = CPRST_RESTORE;
      CPRST_RESTORE: begin
        cprst_rat_valid = !rat_done;
        cprst_bp_valid  = !bp_done;
        if ((rat_done || rat_hs) && (bp_done || bp_hs)) state_nxt = CPRST_DONE;
      end
      CPRST_DONE: begin
        cprst_done = 1'b1;
        state_nxt  = CPRST_IDLE;
      end
      default: state_nxt = CPRST_IDLE;
    endcase
    // Flush overrides everything, including a request arriving in IDLE.
    if (commit_cprst_flush) state_nxt = CPRST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q     <= '0;
      taken_q  <= 1'b0;
      cap_q    <= '0;
      rat_done <= 1'b0;
      bp_done  <= 1'b0;
    end else begin
      if (state == CPRST_IDLE && bru_cprst_req && !commit_cprst_flush) begin
        id_q    <= bru_cprst_id;
        taken_q <= bru_cprst_taken;
      end
      if (commit_cprst_flush) begin
        rat_done <= 1'b0;
        bp_done  <= 1'b0;
      end else if (state == CPRST_READ) begin
        cap_q    <= cpbuf_cprst_data;
        rat_done <= 1'b0;
        bp_done  <= 1'b0;
      end else if (state == CPRST_RESTORE) begin
        if (rat_hs) rat_done <= 1'b1;
        if (bp_hs)  bp_done  <= 1'b1;
      end
    end
  end

  assign cprst_cpbuf_id                  = id_q;
  assign cprst_rat_phy_map_table_valid   = cap_q.phy_map_table_valid;
  assign cprst_rat_phy_map_table_visible = cap_q.phy_map_table_visible;
  assign cprst_bp_local_history          = cap_q.local_history;
  // The mispredicted branch's real outcome enters at the LSB; the oldest bit falls off.
  assign cprst_bp_global_history = UPDATE_GHR ?
                                   {cap_q.global_history[GHR_WIDTH-2:0], taken_q} :
                                   cap_q.global_history[GHR_WIDTH-1:0];
  assign cprst_busy  = (state != CPRST_IDLE);
  assign cprst_state = state;

endmodule

// File: tb/tb_checkpoint_restore.sv
// Directed plus short random checks of checkpoint_restore with UPDATE_GHR=1 and =0 side by side.
module tb_checkpoint_restore;
  import checkpoint_restore_pkg::*;

  localparam int MAPW = 2 * PHY_REG_NUM;
  localparam int BPW  = GHR_W + LOCAL_HIST_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               req = 1'b0;
  logic [CP_ID_W-1:0] req_id = '0;
  logic               req_taken = 1'b0;
  logic               rat_ready = 1'b0;
  logic               bp_ready = 1'b0;
  logic               flush = 1'b0;

  checkpoint_t cp_mem [8];

  // u: history updated with the branch outcome; r: raw restore
  logic                    bru_ready_u, bru_ready_r;
  logic [CP_ID_W-1:0]      cpbuf_id_u, cpbuf_id_r;
  checkpoint_t             cpbuf_data_u, cpbuf_data_r;
  logic                    rat_valid_u, rat_valid_r;
  logic [PHY_REG_NUM-1:0]  map_valid_u, map_valid_r, map_vis_u, map_vis_r;
  logic                    bp_valid_u, bp_valid_r;
  logic [GHR_W-1:0]        ghr_u, ghr_r;
  logic [LOCAL_HIST_W-1:0] lh_u, lh_r;
  logic                    busy_u, busy_r, done_u, done_r;
  cprst_state_t            state_u, state_r;

  assign cpbuf_data_u = cp_mem[cpbuf_id_u];
  assign cpbuf_data_r = cp_mem[cpbuf_id_r];

  checkpoint_restore #(.UPDATE_GHR(1'b1)) u_upd (
    .clk(clk), .rst(rst), .bru_cprst_req(req), .bru_cprst_id(req_id),
    .bru_cprst_taken(req_taken), .cprst_bru_ready(bru_ready_u), .cprst_cpbuf_id(cpbuf_id_u),
    .cpbuf_cprst_data(cpbuf_data_u), .cprst_rat_valid(rat_valid_u),
    .cprst_rat_phy_map_table_valid(map_valid_u), .cprst_rat_phy_map_table_visible(map_vis_u),
    .rat_cprst_ready(rat_ready), .cprst_bp_valid(bp_valid_u), .cprst_bp_global_history(ghr_u),
    .cprst_bp_local_history(lh_u), .bp_cprst_ready(bp_ready), .commit_cprst_flush(flush),
    .cprst_busy(busy_u), .cprst_done(done_u), .cprst_state(state_u)
  );

  checkpoint_restore #(.UPDATE_GHR(1'b0)) u_raw (
    .clk(clk), .rst(rst), .bru_cprst_req(req), .bru_cprst_id(req_id),
    .bru_cprst_taken(req_taken), .cprst_bru_ready(bru_ready_r), .cprst_cpbuf_id(cpbuf_id_r),
    .cpbuf_cprst_data(cpbuf_data_r), .cprst_rat_valid(rat_valid_r),
    .cprst_rat_phy_map_table_valid(map_valid_r), .cprst_rat_phy_map_table_visible(map_vis_r),
    .rat_cprst_ready(rat_ready), .cprst_bp_valid(bp_valid_r), .cprst_bp_global_history(ghr_r),
    .cprst_bp_local_history(lh_r), .bp_cprst_ready(bp_ready), .commit_cprst_flush(flush),
    .cprst_busy(busy_r), .cprst_done(done_r), .cprst_state(state_r)
  );

  int checks = 0;
  int errors = 0;

  logic [MAPW-1:0] rat_u_q[$], rat_r_q[$];
  logic [BPW-1:0]  bp_u_q[$],  bp_r_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic bsy,
                            input logic rv, input logic bv, input logic dn);
    chk({tag, "_ready_u"}, 64'(bru_ready_u), 64'(rdy));
    chk({tag, "_busy_u"},  64'(busy_u),      64'(bsy));
    chk({tag, "_ratv_u"},  64'(rat_valid_u), 64'(rv));
    chk({tag, "_bpv_u"},   64'(bp_valid_u),  64'(bv));
    chk({tag, "_done_u"},  64'(done_u),      64'(dn));
    chk({tag, "_ready_r"}, 64'(bru_ready_r), 64'(rdy));
    chk({tag, "_busy_r"},  64'(busy_r),      64'(bsy));
    chk({tag, "_ratv_r"},  64'(rat_valid_r), 64'(rv));
    chk({tag, "_bpv_r"},   64'(bp_valid_r),  64'(bv));
    chk({tag, "_done_r"},  64'(done_r),      64'(dn));
  endtask

  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] g, input logic t);
    return {g[GHR_W-2:0], t};
  endfunction

  // Expected payloads for an accepted request, taken from the bench's checkpoint store.
  task automatic push_exp(input logic [CP_ID_W-1:0] id, input logic t);
    checkpoint_t c;
    c = cp_mem[id];
    rat_u_q.push_back({c.phy_map_table_valid, c.phy_map_table_visible});
    rat_r_q.push_back({c.phy_map_table_valid, c.phy_map_table_visible});
    bp_u_q.push_back({ghr_shift(c.global_history, t), c.local_history});
    bp_r_q.push_back({c.global_history, c.local_history});
  endtask

  task automatic drop_exp(input string tag);
    chk({tag, "_pending_rat"}, 64'(rat_u_q.size()), 64'd1);
    chk({tag, "_pending_bp"},  64'(bp_u_q.size()),  64'd1);
    rat_u_q.delete(); rat_r_q.delete(); bp_u_q.delete(); bp_r_q.delete();
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every handshake about to complete at the next edge pops one expected payload.
  always @(negedge clk) begin
    if (rst) begin
      if (rat_valid_u && rat_ready) begin
        chk("rat_u_q_nonempty", 64'(rat_u_q.size() != 0), 64'd1);
        if (rat_u_q.size() != 0) chk("rat_payload_u", 64'({map_valid_u, map_vis_u}), 64'(rat_u_q.pop_front()));
      end
      if (rat_valid_r && rat_ready) begin
        chk("rat_r_q_nonempty", 64'(rat_r_q.size() != 0), 64'd1);
        if (rat_r_q.size() != 0) chk("rat_payload_r", 64'({map_valid_r, map_vis_r}), 64'(rat_r_q.pop_front()));
      end
      if (bp_valid_u && bp_ready) begin
        chk("bp_u_q_nonempty", 64'(bp_u_q.size() != 0), 64'd1);
        if (bp_u_q.size() != 0) chk("bp_payload_u", 64'({ghr_u, lh_u}), 64'(bp_u_q.pop_front()));
      end
      if (bp_valid_r && bp_ready) begin
        chk("bp_r_q_nonempty", 64'(bp_r_q.size() != 0), 64'd1);
        if (bp_r_q.size() != 0) chk("bp_payload_r", 64'({ghr_r, lh_r}), 64'(bp_r_q.pop_front()));
      end
    end
  end

  logic [BPW-1:0]     held;
  logic [CP_ID_W-1:0] rid;
  logic               rtk;
  bit                 seen;

  initial begin
    for (int i = 0; i < 8; i++) begin
      cp_mem[i].phy_map_table_valid   = $urandom;
      cp_mem[i].phy_map_table_visible = $urandom;
      cp_mem[i].global_history        = GHR_W'($urandom);
      cp_mem[i].local_history         = LOCAL_HIST_W'($urandom);
    end
    cp_mem[0].global_history = 16'b1;
    cp_mem[1].global_history = 16'b11;

    // reset state
    repeat (2) smp();
    chk_status("reset", 1, 0, 0, 0, 0);
    chk("reset_cpbuf_id", 64'(cpbuf_id_u), 64'd0);
    chk("reset_ghr_u", 64'(ghr_u), 64'd0);
    nc();
    rst = 1'b1;

    // minimum latency, id1 taken
    req = 1; req_id = 3'd1; req_taken = 1; rat_ready = 1; bp_ready = 1;
    smp(); chk("t1_accept", 64'(bru_ready_u), 64'd1); push_exp(3'd1, 1'b1);
    nc(); req = 0;
    smp(); chk_status("t1_c1", 0, 1, 0, 0, 0); chk("t1_cpbuf_id", 64'(cpbuf_id_u), 64'd1);
    nc(); smp(); chk_status("t1_c2", 0, 1, 1, 1, 0);
    chk("t1_ghr_u", 64'(ghr_u), 64'h7); chk("t1_ghr_r", 64'(ghr_r), 64'h3);
    nc(); smp(); chk_status("t1_c3", 0, 1, 0, 0, 1);
    nc(); smp(); chk_status("t1_c4", 1, 0, 0, 0, 0);

    // id0 not taken
    nc(); req = 1; req_id = 3'd0; req_taken = 0;
    smp(); chk("t2_accept", 64'(bru_ready_u), 64'd1); push_exp(3'd0, 1'b0);
    nc(); req = 0;
    smp(); chk("t2_cpbuf_id", 64'(cpbuf_id_r), 64'd0);
    nc(); smp(); chk_status("t2_c2", 0, 1, 1, 1, 0);
    chk("t2_ghr_r", 64'(ghr_r), 64'h1); chk("t2_ghr_u", 64'(ghr_u), 64'h2);
    chk("t2_map_valid", 64'(map_valid_r), 64'(cp_mem[0].phy_map_table_valid));
    chk("t2_map_vis", 64'(map_vis_r), 64'(cp_mem[0].phy_map_table_visible));
    nc(); smp(); chk_status("t2_c3", 0, 1, 0, 0, 1);

    // predictor stalls three cycles
    nc(); req = 1; req_id = 3'd2; req_taken = 1; rat_ready = 1; bp_ready = 0;
    smp(); chk("t3_accept", 64'(bru_ready_u), 64'd1); push_exp(3'd2, 1'b1);
    nc(); req = 0; smp();
    nc(); smp(); chk_status("t3_c2", 0, 1, 1, 1, 0); held = {ghr_u, lh_u};
    nc(); smp(); chk_status("t3_c3", 0, 1, 0, 1, 0); chk("t3_hold3", 64'({ghr_u, lh_u}), 64'(held));
    nc(); smp(); chk_status("t3_c4", 0, 1, 0, 1, 0); chk("t3_hold4", 64'({ghr_u, lh_u}), 64'(held));
    nc(); bp_ready = 1;
    smp(); chk_status("t3_c5", 0, 1, 0, 1, 0); chk("t3_hold5", 64'({ghr_u, lh_u}), 64'(held));
    nc(); smp(); chk_status("t3_c6", 0, 1, 0, 0, 1);
    nc(); smp(); chk_status("t3_c7", 1, 0, 0, 0, 0);

    // request while busy is ignored, then accepted once ready returns
    nc(); req = 1; req_id = 3'd3; req_taken = 0;
    smp(); chk("t4_accept_a", 64'(bru_ready_u), 64'd1); push_exp(3'd3, 1'b0);
    nc(); req_id = 3'd4; req_taken = 1;
    smp(); chk("t4_c1_ready", 64'(bru_ready_u), 64'd0); chk("t4_c1_id", 64'(cpbuf_id_u), 64'd3);
    nc(); smp(); chk("t4_c2_ready", 64'(bru_ready_u), 64'd0);
    nc(); smp(); chk_status("t4_c3", 0, 1, 0, 0, 1);
    nc(); smp(); chk("t4_accept_b", 64'(bru_ready_u), 64'd1); push_exp(3'd4, 1'b1);
    nc(); req = 0;
    smp(); chk("t4_new_id", 64'(cpbuf_id_u), 64'd4); chk("t4_busy", 64'(busy_u), 64'd1);
    nc(); smp(); chk_status("t4_restore", 0, 1, 1, 1, 0);
    nc(); smp(); chk_status("t4_done", 0, 1, 0, 0, 1);

    // flush in RESTORE aborts without a done pulse
    nc(); req = 1; req_id = 3'd5; req_taken = 1; rat_ready = 0; bp_ready = 0;
    smp(); chk("t5_accept", 64'(bru_ready_u), 64'd1); push_exp(3'd5, 1'b1);
    nc(); req = 0; smp();
    nc(); smp(); chk_status("t5_c2", 0, 1, 1, 1, 0);
    nc(); flush = 1;
    smp(); chk_status("t5_c3", 0, 1, 1, 1, 0);
    nc(); flush = 0;
    smp(); chk_status("t5_c4", 1, 0, 0, 0, 0);
    nc(); smp(); chk_status("t5_c5", 1, 0, 0, 0, 0);
    drop_exp("t5");

    // flush beats a simultaneous request in IDLE
    nc(); req = 1; req_id = 3'd6; flush = 1;
    smp(); chk_status("t6_c0", 1, 0, 0, 0, 0);
    nc(); req = 0; flush = 0;
    smp(); chk_status("t6_c1", 1, 0, 0, 0, 0); chk("t6_id_kept", 64'(cpbuf_id_u), 64'd5);

    // async reset mid-restore
    nc(); req = 1; req_id = 3'd7; req_taken = 0;
    smp(); push_exp(3'd7, 1'b0);
    nc(); req = 0; smp();
    nc(); smp(); chk_status("t7_c2", 0, 1, 1, 1, 0);
    #1 rst = 1'b0;
    #1 chk_status("t7_rst", 1, 0, 0, 0, 0); chk("t7_rst_id", 64'(cpbuf_id_u), 64'd0);
    drop_exp("t7");
    nc(); rst = 1'b1;

    // random transactions with random channel stalls
    for (int n = 0; n < 6; n++) begin
      rid = CP_ID_W'($urandom_range(0, 7));
      rtk = 1'($urandom_range(0, 1));
      nc(); req = 1; req_id = rid; req_taken = rtk;
      rat_ready = 1'($urandom_range(0, 1)); bp_ready = 1'($urandom_range(0, 1));
      smp(); chk("rnd_accept", 64'(bru_ready_u), 64'd1); push_exp(rid, rtk);
      seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
        nc(); req = 0;
        rat_ready = 1'($urandom_range(0, 1)); bp_ready = 1'($urandom_range(0, 1));
        smp();
        if (done_u) begin
          seen = 1;
          chk("rnd_done_r", 64'(done_r), 64'd1);
        end
      end
      chk("rnd_done_in_budget", 64'(seen), 64'd1);
    end

    nc(); rat_ready = 0; bp_ready = 0; smp();
    chk("end_rat_q_empty", 64'(rat_u_q.size() + rat_r_q.size()), 64'd0);
    chk("end_bp_q_empty",  64'(bp_u_q.size() + bp_r_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/checkpoint_restore.md
Name: checkpoint_restore

Overview:
- Consumer side of the checkpoint protocol: on a branch mispredict reported by the BRU, reads the tagged checkpoint back from checkpoint_buffer.
- Restores RAT valid/visible maps to rename and the corrected branch history to the predictor over two independent valid/ready channels.
- Sits between execute (BRU), checkpoint_buffer, rename and the branch predictor.
- Single outstanding restore; aborted by a commit flush.

Parameters:
- CP_ID_WIDTH, `CHECKPOINT_ID_WIDTH, checkpoint id width.
- GHR_WIDTH, `GLOBAL_HISTORY_WIDTH, global history width (test default 16).
- UPDATE_GHR, 1, 1 = shift actual branch outcome into restored global history; 0 = restore unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- bru_cprst_req  in  1  mispredict restore request.
- bru_cprst_id  in  CP_ID_WIDTH  checkpoint id of mispredicted branch.
- bru_cprst_taken  in  1  actual branch outcome.
- cprst_bru_ready  out  1  request accepted when req&&ready.
- cprst_cpbuf_id  out  CP_ID_WIDTH  read id to checkpoint_buffer.
- cpbuf_cprst_data  in  checkpoint_t  combinational read data for cprst_cpbuf_id.
- cprst_rat_valid  out  1  RAT restore valid.
- cprst_rat_phy_map_table_valid  out  `PHY_REG_NUM  restored valid map.
- cprst_rat_phy_map_table_visible  out  `PHY_REG_NUM  restored visible map.
- rat_cprst_ready  in  1  rename accepts RAT restore.
- cprst_bp_valid  out  1  predictor restore valid.
- cprst_bp_global_history  out  GHR_WIDTH  corrected global history.
- cprst_bp_local_history  out  checkpoint_t.local_history width  restored local history.
- bp_cprst_ready  in  1  predictor accepts restore.
- commit_cprst_flush  in  1  pipeline flush; aborts restore.
- cprst_busy  out  1  state != IDLE.
- cprst_done  out  1  one-cycle pulse: restore completed.

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0 except cprst_bru_ready=1. Captured id, taken and checkpoint registers cleared.
- FSM states: IDLE, READ, RESTORE, DONE.
- IDLE:
  - cprst_bru_ready=1.
  - On req, latch id and taken; next state READ.
- READ:
  - cprst_cpbuf_id = latched id (driven from the register in every state; 0 after reset).
  - At the clock edge, capture cpbuf_cprst_data into an internal checkpoint register; clear rat_done and bp_done; next state RESTORE.
- RESTORE:
  - cprst_rat_valid = !rat_done; cprst_bp_valid = !bp_done.
  - Payloads come from the captured register and are stable while valid is high.
  - cprst_bp_global_history = UPDATE_GHR ? {cap.global_history[GHR_WIDTH-2:0], taken} : cap.global_history.
  - valid&&ready on a channel sets its done flag; valid drops the next cycle.
  - When both channels have handshaken (same cycle or different cycles), next state DONE.
- DONE: cprst_done=1 for exactly one cycle; next state IDLE.
- Minimum latency: req accepted at edge E0 → READ in cycle 1 → RESTORE in cycle 2 → DONE in cycle 3 (with both readies high) → ready again in cycle 4.
- cprst_bru_ready=0 in every state other than IDLE. A req while not ready is ignored, not queued; the BRU must hold it.
- commit_cprst_flush in any state:
  - Next state IDLE, done flags cleared, no cprst_done pulse.
  - Flush wins over a simultaneous req in IDLE (req not accepted).
  - Flush in the same cycle as a channel handshake: the handshake counts at the receiver, but the FSM still goes to IDLE.
- Valid/ready rules: valid never depends combinationally on ready; payload held constant while valid && !ready.
- Async reset mid-restore: immediate return to IDLE; valids drop without handshake.
- GHR width arithmetic: shift truncates the MSB; no carry.

Decomposition:
- checkpoint_t, CP id width, PHY_REG_NUM, history widths remain in the shared config/common package.
- Add cprst_state_t enum (IDLE/READ/RESTORE/DONE) to common.
- No sub-module needed; the FSM and two done flags live in one module.

Test Plan:
- Reset with rst=0 mid-simulation → all valids 0, cprst_bru_ready=1, cprst_busy=0, cprst_cpbuf_id=0.
- cpbuf id1 holds global_history='b11; req id=1, taken=1, both readies=1 → cpbuf_id=1 in cycle 1; rat_valid=bp_valid=1 in cycle 2 with bp_global_history='b111; cprst_done=1 in cycle 3; ready=1 in cycle 4.
- Same with UPDATE_GHR=0, taken=0, id0 global_history='b1 → bp_global_history='b1; visible/valid maps equal the checkpoint values.
- rat_ready=1 immediately, bp_ready held 0 for 3 cycles → rat_valid high 1 cycle only, bp_valid held 4 cycles with a stable payload, done pulses the cycle after the bp handshake.
- Second req asserted while busy → ignored (ready=0); req held → accepted the cycle ready returns, new id on cprst_cpbuf_id.
- commit_cprst_flush asserted in RESTORE with bp_ready=0 → IDLE next cycle, no cprst_done, valids 0; flush+req in IDLE → req not accepted.
